// File: rtl/pattern_select_ctrl.sv
// Push-button front end for the LED pattern display: synchronises and debounces
// the next/prev keys, turns presses (and optional auto-repeat) into wrap-around select steps.
module pattern_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int NUM_PATTERNS    = 5,
    parameter int SEL_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_next_n,
    input  logic             key_prev_n,
    input  logic             hold,
    output logic [SEL_W-1:0] sel,
    output logic             sel_changed,
    output logic             next_pressed,
    output logic             prev_pressed
);

    localparam int               DW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]    DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_PATTERNS - 1);

    // Bit 0 is the next key, bit 1 the prev key throughout.
    logic [1:0]       raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       pressed_r;
    logic [1:0]       pressed_d_r;
    logic [1:0]       press_s;
    logic [1:0]       repeat_s;
    logic [1:0]       step_s;
    logic [DW-1:0]    db_cnt_r [2];
    logic [SEL_W-1:0] sel_r;
    logic             sel_changed_r;

    assign raw_s = {key_prev_n, key_next_n};

    // Two-flop synchroniser, idling at the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: a level change is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed_r <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                db_cnt_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if ((~sync2_r[k]) != pressed_r[k]) begin
                    if (db_cnt_r[k] == DB_LAST) begin
                        pressed_r[k] <= ~sync2_r[k];
                        db_cnt_r[k]  <= '0;
                    end else begin
                        db_cnt_r[k] <= db_cnt_r[k] + DW'(1);
                    end
                end else begin
                    db_cnt_r[k] <= '0;
                end
            end
        end
    end

    // Delayed debounced level for press-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed_d_r <= 2'b00;
        end else begin
            pressed_d_r <= pressed_r;
        end
    end

    assign press_s = pressed_r & ~pressed_d_r;

    generate
        if (REPEAT_CYCLES > 0) begin : g_repeat
            localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
            localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES);
            logic [RW-1:0] rep_cnt_r [2];

            // Counter is 0 in the press-event cycle, so it hits REP_LAST every REPEAT_CYCLES after it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < 2; k++) begin
                        rep_cnt_r[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        if (!pressed_r[k]) begin
                            rep_cnt_r[k] <= '0;
                        end else if (rep_cnt_r[k] == REP_LAST) begin
                            rep_cnt_r[k] <= RW'(1);
                        end else begin
                            rep_cnt_r[k] <= rep_cnt_r[k] + RW'(1);
                        end
                    end
                end
            end

            // Repeat event decode.
            always_comb begin
                repeat_s = 2'b00;
                for (int k = 0; k < 2; k++) begin
                    if (pressed_r[k] && (rep_cnt_r[k] == REP_LAST)) begin
                        repeat_s[k] = 1'b1;
                    end else begin
                        repeat_s[k] = 1'b0;
                    end
                end
            end
        end else begin : g_no_repeat
            assign repeat_s = 2'b00;
        end
    endgenerate

    assign step_s = press_s | repeat_s;

    // Select register: coincident opposite steps cancel, hold discards steps outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r         <= '0;
            sel_changed_r <= 1'b0;
        end else if (!hold && (step_s[0] ^ step_s[1])) begin
            sel_changed_r <= 1'b1;
            if (step_s[0]) begin
                sel_r <= (sel_r == SEL_LAST) ? {SEL_W{1'b0}} : sel_r + SEL_W'(1);
            end else begin
                sel_r <= (sel_r == {SEL_W{1'b0}}) ? SEL_LAST : sel_r - SEL_W'(1);
            end
        end else begin
            sel_changed_r <= 1'b0;
        end
    end

    assign sel          = sel_r;
    assign sel_changed  = sel_changed_r;
    assign next_pressed = pressed_r[0];
    assign prev_pressed = pressed_r[1];

endmodule

// File: tb/tb_pattern_select_ctrl.sv
// Bench for pattern_select_ctrl: two instances (no repeat / repeat every 8 cycles)
// share the key stimulus and are checked every cycle against a behavioural model.
module tb_pattern_select_ctrl;

    localparam int D  = 4;
    localparam int NP = 5;
    localparam int R  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_next_n = 1'b1;
    logic       key_prev_n = 1'b1;
    logic       hold = 1'b0;
    logic [2:0] sel_a, sel_b;
    logic       chg_a, chg_b, np_a, pp_a, np_b, pp_b;

    pattern_select_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .NUM_PATTERNS(NP), .SEL_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_next_n(key_next_n), .key_prev_n(key_prev_n), .hold(hold),
        .sel(sel_a), .sel_changed(chg_a), .next_pressed(np_a), .prev_pressed(pp_a));

    pattern_select_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .NUM_PATTERNS(NP), .SEL_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_next_n(key_next_n), .key_prev_n(key_prev_n), .hold(hold),
        .sel(sel_b), .sel_changed(chg_b), .next_pressed(np_b), .prev_pressed(pp_b));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state; t counts rising edges since reset release.
    int t;
    int m_sel_a, m_sel_b;
    bit m_chg_a, m_chg_b;
    bit m_pr [2];
    int run [2];
    int acc [2];
    int hist [2][$];
    int pulses_a, pulses_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_sel_a = 0; m_sel_b = 0;
        m_chg_a = 1'b0; m_chg_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_pr[k] = 1'b0; run[k] = 0; acc[k] = 0;
            hist[k].delete();
            hist[k].push_back(1);
            hist[k].push_back(1);
        end
    endtask

    task automatic apply(inout int s, inout bit c, input bit n, input bit p, input bit h);
        if (!h && (n != p)) begin
            c = 1'b1;
            s = n ? (s + 1) % NP : (s + NP - 1) % NP;
        end else begin
            c = 1'b0;
        end
    endtask

    task automatic model_edge(input bit kn, input bit kp, input bit h);
        bit raw [2];
        bit st_a [2];
        bit st_b [2];
        int ss;
        raw[0] = kn; raw[1] = kp;
        t++;
        for (int k = 0; k < 2; k++) begin
            // A step fires on the edge after acceptance, then every R edges while still pressed.
            st_a[k] = m_pr[k] && (t - 1 == acc[k]);
            st_b[k] = m_pr[k] && ((t - 1 - acc[k]) % R == 0);
            ss = hist[k][hist[k].size() - 2];
            if ((ss == 0) != m_pr[k]) begin
                run[k]++;
                if (run[k] == D) begin
                    m_pr[k] = (ss == 0);
                    run[k]  = 0;
                    acc[k]  = t;
                end
            end else begin
                run[k] = 0;
            end
            hist[k].push_back(int'(raw[k]));
            if (hist[k].size() > 3) void'(hist[k].pop_front());
        end
        apply(m_sel_a, m_chg_a, st_a[0], st_a[1], h);
        apply(m_sel_b, m_chg_b, st_b[0], st_b[1], h);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(key_next_n, key_prev_n, hold);
            #1;
            chk("sel_a", sel_a, m_sel_a);
            chk("chg_a", chg_a, m_chg_a);
            chk("sel_b", sel_b, m_sel_b);
            chk("chg_b", chg_b, m_chg_b);
            chk("next_pressed", np_a, m_pr[0]);
            chk("prev_pressed", pp_a, m_pr[1]);
            chk("next_pressed_b", np_b, m_pr[0]);
            chk("prev_pressed_b", pp_b, m_pr[1]);
            if (chg_a) pulses_a++;
            if (chg_b) pulses_b++;
        end
    endtask

    // Asynchronous reset applied 1 time unit after an edge; outputs must clear immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_sel", sel_a, 0);
        chk("rst_chg", chg_a, 0);
        chk("rst_np", np_a, 0);
        chk("rst_pp", pp_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_np_b", np_b, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic press_next(input int n_low, input int n_high);
        key_next_n = 1'b0; cyc(n_low);
        key_next_n = 1'b1; cyc(n_high);
    endtask

    int exp_sel;

    initial begin
        model_reset();
        pulses_a = 0; pulses_b = 0;
        #2;
        chk("reset_sel", sel_a, 0);
        chk("reset_np", np_a, 0);
        #10;
        rst_n = 1'b1;

        // 1: first press latency, then four more presses wrap 1,2,3,4,0
        key_next_n = 1'b0;
        cyc(5);
        chk("t1_np_e5", np_a, 0);
        cyc(1);
        chk("t1_np_e6", np_a, 1);
        chk("t1_sel_e6", sel_a, 0);
        cyc(1);
        chk("t1_sel_e7", sel_a, 1);
        chk("t1_chg_e7", chg_a, 1);
        cyc(1);
        chk("t1_chg_e8", chg_a, 0);
        key_next_n = 1'b1; cyc(8);
        for (int i = 0; i < 4; i++) press_next(8, 8);
        chk("t1_wrap", sel_a, 0);

        // 2: prev wraps 0 -> 4 -> 3
        pulses_a = 0;
        key_prev_n = 1'b0; cyc(8); key_prev_n = 1'b1; cyc(8);
        chk("t2_sel4", sel_a, 4);
        key_prev_n = 1'b0; cyc(8); key_prev_n = 1'b1; cyc(8);
        chk("t2_sel3", sel_a, 3);
        chk("t2_pulses", pulses_a, 2);

        // 3: short glitch ignored, bounce train gives a single step
        pulses_a = 0;
        press_next(3, 10);
        chk("t3_glitch_sel", sel_a, 3);
        chk("t3_glitch_pulses", pulses_a, 0);
        for (int i = 0; i < 5; i++) begin
            key_next_n = (i % 2 == 1); cyc(2);
        end
        cyc(10);
        key_next_n = 1'b1; cyc(10);
        chk("t3_bounce_sel", sel_a, 4);
        chk("t3_bounce_pulses", pulses_a, 1);

        // 4: coincident presses cancel, then next alone steps
        pulses_a = 0;
        key_next_n = 1'b0; key_prev_n = 1'b0; cyc(12);
        key_next_n = 1'b1; key_prev_n = 1'b1; cyc(10);
        chk("t4_both_sel", sel_a, 4);
        chk("t4_both_pulses", pulses_a, 0);
        press_next(8, 8);
        chk("t4_next_sel", sel_a, 0);

        // 5: hold discards the press, no replay after hold drops
        pulses_a = 0;
        hold = 1'b1; key_next_n = 1'b0; cyc(10);
        hold = 1'b0; cyc(5);
        key_next_n = 1'b1; cyc(10);
        chk("t5_hold_sel", sel_a, 0);
        chk("t5_hold_pulses", pulses_a, 0);
        press_next(8, 8);
        chk("t5_after_sel", sel_a, 1);

        // 6: auto-repeat on dut_b, then reset mid-hold
        do_reset();
        pulses_b = 0;
        key_next_n = 1'b0; cyc(45);
        key_next_n = 1'b1; cyc(10);
        chk("t6_repeat_pulses", pulses_b, 6);
        chk("t6_repeat_sel", sel_b, 1);
        chk("t6_norepeat_sel", sel_a, 1);
        key_next_n = 1'b0; cyc(20);
        do_reset();
        key_next_n = 1'b1; cyc(10);
        chk("t6_post_rst_sel", sel_b, 0);

        // Randomised key/hold segments against the model
        for (int i = 0; i < 40; i++) begin
            key_next_n = 1'($urandom_range(0, 1));
            key_prev_n = 1'($urandom_range(0, 1));
            hold       = ($urandom_range(0, 3) == 0);
            cyc($urandom_range(1, 14));
        end
        exp_sel = m_sel_a;
        chk("rand_final_sel", sel_a, exp_sel);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
